// File: rtl/axi_prewrapper_mc.sv
// axi_prewrapper_mc: register-mapped wrapper driving one DUT op and SC_NBR scan-chain dumps,
// with per-chain capture buffers, watchdog abort, sticky error flags and a done interrupt.
module axi_prewrapper_mc #(
  parameter int SC_NBR  = 4,
  parameter int IN_W    = 128,
  parameter int OUT_W   = 128,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  axi_wr_en,
  input  logic [31:0]           axi_wr_addr,
  input  logic [31:0]           axi_wr_msg,
  input  logic [31:0]           axi_rd_addr,
  output logic [31:0]           axi_rd_msg,
  output logic [IN_W-1:0]       dut_input_vec,
  input  logic [OUT_W-1:0]      dut_output_vec,
  output logic                  dut_val_op,
  input  logic                  dut_op_ack,
  input  logic                  dut_op_commit,
  output logic                  dut_commit_ack,
  output logic                  dut_sen,
  output logic [SC_NBR-1:0]     dft_val_op,
  input  logic [SC_NBR-1:0]     dft_op_ack,
  input  logic [32*SC_NBR-1:0]  dft_output_data,
  input  logic [SC_NBR-1:0]     dft_output_strobe,
  input  logic [SC_NBR-1:0]     dft_op_commit,
  output logic [SC_NBR-1:0]     dft_commit_ack,
  output logic                  irq
);
  localparam int NIN  = IN_W / 32;
  localparam int NOUT = OUT_W / 32;
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int WW   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DUT_REQ, S_DUT_WAIT, S_SCAN_REQ, S_SCAN_COL, S_DONE, S_ERR
  } state_t;

  state_t             r_state, w_next;
  logic [9:0]         w_widx, w_ridx;
  logic               w_ctrl_wr, w_start_dut, w_start_scan, w_clear, w_wd_exp, w_wait;
  logic [SC_NBR-1:0]  r_mask, r_acked, r_done, r_ovf, r_dft_cack, w_acked, w_done;
  logic [CW-1:0]      r_cnt [SC_NBR];
  logic [31:0]        r_buf [SC_NBR][DEPTH];
  logic [31:0]        r_in [NIN];
  logic [31:0]        r_out [NOUT];
  logic [31:0]        r_cycles, w_rd;
  logic               r_busy_err, r_to_err, r_dut_cack;
  logic [WW-1:0]      r_wd;
  logic               w_unused;

  assign w_unused     = ^{axi_wr_addr[31:12], axi_wr_addr[1:0], axi_rd_addr[31:12], axi_rd_addr[1:0]};
  assign w_widx       = axi_wr_addr[11:2];
  assign w_ridx       = axi_rd_addr[11:2];
  assign w_ctrl_wr    = axi_wr_en && w_widx == 10'd0;
  assign w_start_dut  = w_ctrl_wr && axi_wr_msg[0];
  assign w_start_scan = w_ctrl_wr && axi_wr_msg[1] && !axi_wr_msg[0];
  assign w_clear      = w_ctrl_wr && axi_wr_msg[2] && r_state == S_IDLE;
  assign w_acked      = r_acked | (dft_op_ack & r_mask);
  assign w_done       = r_done | (dft_op_commit & r_mask);
  assign w_wait       = r_state inside {S_DUT_REQ, S_DUT_WAIT, S_SCAN_REQ, S_SCAN_COL};
  assign w_wd_exp     = r_wd == WW'(TIMEOUT - 1);

  assign dut_val_op     = r_state == S_DUT_REQ;
  assign dut_sen        = r_state == S_SCAN_REQ || r_state == S_SCAN_COL;
  assign dft_val_op     = r_state == S_SCAN_REQ ? r_mask & ~r_acked : '0;
  assign irq            = r_state == S_DONE;
  assign dut_commit_ack = r_dut_cack;
  assign dft_commit_ack = r_dft_cack;

  for (genvar k = 0; k < NIN; k++) begin : g_in
    assign dut_input_vec[32*k +: 32] = r_in[k];
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     w_next = w_start_dut ? S_DUT_REQ :
                           w_start_scan ? (r_mask == '0 ? S_DONE : S_SCAN_REQ) : S_IDLE;
      S_DUT_REQ:  w_next = dut_op_ack ? S_DUT_WAIT : S_DUT_REQ;
      S_DUT_WAIT: w_next = dut_op_commit ? S_DONE : S_DUT_WAIT;
      S_SCAN_REQ: w_next = (w_acked & r_mask) == r_mask ? S_SCAN_COL : S_SCAN_REQ;
      S_SCAN_COL: w_next = (w_done & r_mask) == r_mask ? S_DONE : S_SCAN_COL;
      default:    w_next = S_IDLE;
    endcase
    // the watchdog only fires when the state would otherwise not move
    if (w_wait && w_wd_exp && w_next == r_state) w_next = S_ERR;
  end

  always_comb begin
    w_rd = '0;
    if (w_ridx == 10'd1) w_rd = {16'(r_ovf), 10'd0, r_to_err, r_busy_err, r_state != S_IDLE, r_state};
    if (w_ridx == 10'd2) w_rd = 32'(r_mask);
    if (w_ridx == 10'd3) w_rd = r_cycles;
    for (int k = 0; k < NIN; k++) if (w_ridx == 10'(16 + k)) w_rd = r_in[k];
    for (int k = 0; k < NOUT; k++) if (w_ridx == 10'(32 + k)) w_rd = r_out[k];
    for (int c = 0; c < SC_NBR; c++) begin
      if (w_ridx == 10'(64 + c)) w_rd = 32'(r_cnt[c]);
      for (int j = 0; j < DEPTH; j++) if (w_ridx == 10'(128 + c*DEPTH + j)) w_rd = r_buf[c][j];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_mask     <= '1;
      r_acked    <= '0;
      r_done     <= '0;
      r_ovf      <= '0;
      r_busy_err <= 1'b0;
      r_to_err   <= 1'b0;
      r_cycles   <= '0;
      r_wd       <= '0;
      r_dut_cack <= 1'b0;
      r_dft_cack <= '0;
      axi_rd_msg <= '0;
      for (int k = 0; k < NIN; k++) r_in[k] <= '0;
      for (int k = 0; k < NOUT; k++) r_out[k] <= '0;
      for (int c = 0; c < SC_NBR; c++) begin
        r_cnt[c] <= '0;
        for (int j = 0; j < DEPTH; j++) r_buf[c][j] <= '0;
      end
    end else begin
      r_state    <= w_next;
      axi_rd_msg <= w_rd;
      r_wd       <= (w_wait && w_next == r_state) ? r_wd + 1'b1 : '0;
      r_dut_cack <= r_state == S_DUT_WAIT && dut_op_commit;
      r_dft_cack <= r_state == S_SCAN_COL ? dft_op_commit & r_mask : '0;
      if (r_state != S_IDLE && r_cycles != '1) r_cycles <= r_cycles + 32'd1;
      if (r_state == S_IDLE && (w_start_dut || w_start_scan)) r_cycles <= 32'd1;
      if (w_ctrl_wr && (axi_wr_msg[0] || axi_wr_msg[1]) && r_state != S_IDLE) r_busy_err <= 1'b1;
      if (w_next == S_ERR) r_to_err <= 1'b1;
      if (r_state == S_DUT_WAIT && dut_op_commit)
        for (int k = 0; k < NOUT; k++) r_out[k] <= dut_output_vec[32*k +: 32];
      if (axi_wr_en && w_widx == 10'd2) r_mask <= axi_wr_msg[SC_NBR-1:0];
      for (int k = 0; k < NIN; k++) if (axi_wr_en && w_widx == 10'(16 + k)) r_in[k] <= axi_wr_msg;
      if (r_state == S_SCAN_REQ) r_acked <= w_acked;
      if (r_state == S_SCAN_COL) r_done <= w_done;
      for (int c = 0; c < SC_NBR; c++)
        if (r_state == S_SCAN_COL && r_mask[c] && dft_output_strobe[c]) begin
          if (r_cnt[c] == CW'(DEPTH)) r_ovf[c] <= 1'b1;
          else begin
            r_buf[c][r_cnt[c][AW-1:0]] <= dft_output_data[32*c +: 32];
            r_cnt[c] <= r_cnt[c] + 1'b1;
          end
        end
      if (r_state == S_IDLE && w_start_scan) begin
        r_acked <= '0;
        r_done  <= '0;
        for (int c = 0; c < SC_NBR; c++) r_cnt[c] <= '0;
      end
      if (w_clear) begin
        r_busy_err <= 1'b0;
        r_to_err   <= 1'b0;
        r_ovf      <= '0;
        for (int c = 0; c < SC_NBR; c++) r_cnt[c] <= '0;
      end
    end
  end
endmodule
